// File: rtl/axil_mpi_master.sv
// AXI4-Lite slave that issues single cpu_wr/cpu_rd accesses on the MPI register bus.
// One transaction in flight; writes and reads arbitrated round-robin when both are pending.
module axil_mpi_master #(
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int RD_LATENCY     = 1
) (
  input  logic                        clks,
  input  logic                        reset,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  input  logic [CPU_DATA_WIDTH-1:0]   s_wdata,
  input  logic [CPU_DATA_WIDTH/8-1:0] s_wstrb,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  output logic [1:0]                  s_bresp,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic [CPU_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        cpu_wr,
  output logic [CPU_ADDR_WIDTH-1:0]   cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0]   cpu_data_in,
  output logic                        cpu_rd,
  input  logic [CPU_DATA_WIDTH-1:0]   cpu_data_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] LAT_LAST    = 3'(RD_LATENCY - 1);

  if (AXI_ADDR_WIDTH < CPU_ADDR_WIDTH + 2 || RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_params
    $error("axil_mpi_master: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_WAIT, RD_RESP} state_t;

  state_t                      state, state_nxt;
  logic [2:0]                  cnt, cnt_nxt;
  logic                        last_was_wr, last_was_wr_nxt;
  logic                        wr_elig, rd_elig, granting;
  logic                        grant_wr, grant_rd, wr_hs, rd_hs;
  logic                        full_strb, rd_done;
  logic                        awready_nxt, wready_nxt, arready_nxt;
  logic                        bvalid_nxt, rvalid_nxt;
  logic                        cpu_wr_nxt, cpu_rd_nxt;
  logic [1:0]                  bresp_nxt;
  logic [CPU_ADDR_WIDTH-1:0]   addr_nxt;
  logic [CPU_DATA_WIDTH-1:0]   data_in_nxt, rdata_nxt;
  logic                        unused_addr_bits;

  // Only the word-address slice is decoded; byte lanes and upper bits are don't-care.
  assign unused_addr_bits = ^{s_awaddr, s_araddr};

  assign wr_elig   = s_awvalid & s_wvalid;
  assign rd_elig   = s_arvalid;
  assign granting  = s_awready | s_arready;
  // A grant is decided one cycle ahead of the registered ready pulse.
  assign grant_wr  = (state == IDLE) & ~granting & wr_elig & (~rd_elig | ~last_was_wr);
  assign grant_rd  = (state == IDLE) & ~granting & rd_elig & ~grant_wr;
  assign wr_hs     = s_awready & s_wready & s_awvalid & s_wvalid;
  assign rd_hs     = s_arready & s_arvalid;
  assign full_strb = &s_wstrb;
  assign rd_done   = (state == RD_WAIT) && (cnt == LAT_LAST);

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_hs) begin
          state_nxt = WR;
        end else if (rd_hs) begin
          state_nxt = RD;
        end
      end
      WR:      state_nxt = WR_RESP;
      WR_RESP: if (s_bready) state_nxt = IDLE;
      RD:      state_nxt = RD_WAIT;
      RD_WAIT: if (rd_done) state_nxt = RD_RESP;
      RD_RESP: if (s_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    awready_nxt     = grant_wr;
    wready_nxt      = grant_wr;
    arready_nxt     = grant_rd;
    cpu_wr_nxt      = 1'b0;
    cpu_rd_nxt      = 1'b0;
    bvalid_nxt      = s_bvalid;
    rvalid_nxt      = s_rvalid;
    bresp_nxt       = s_bresp;
    addr_nxt        = cpu_wr_addr;
    data_in_nxt     = cpu_data_in;
    rdata_nxt       = s_rdata;
    last_was_wr_nxt = last_was_wr;
    cnt_nxt         = (state == RD_WAIT) ? cnt + 3'd1 : 3'd0;

    if (grant_wr) begin
      last_was_wr_nxt = 1'b1;
    end else if (grant_rd) begin
      last_was_wr_nxt = 1'b0;
    end

    // Partial-strobe writes never reach the bus; only the error response records them.
    if (wr_hs) begin
      if (full_strb) begin
        cpu_wr_nxt  = 1'b1;
        addr_nxt    = s_awaddr[CPU_ADDR_WIDTH+1:2];
        data_in_nxt = s_wdata;
        bresp_nxt   = RESP_OKAY;
      end else begin
        bresp_nxt   = RESP_SLVERR;
      end
    end

    if (rd_hs) begin
      cpu_rd_nxt = 1'b1;
      addr_nxt   = s_araddr[CPU_ADDR_WIDTH+1:2];
    end

    case (state)
      WR:      bvalid_nxt = 1'b1;
      WR_RESP: if (s_bready) bvalid_nxt = 1'b0;
      RD_WAIT: begin
        if (rd_done) begin
          rvalid_nxt = 1'b1;
          rdata_nxt  = cpu_data_out;
        end
      end
      RD_RESP: if (s_rready) rvalid_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      s_awready   <= 1'b0;
      s_wready    <= 1'b0;
      s_arready   <= 1'b0;
      s_bvalid    <= 1'b0;
      s_rvalid    <= 1'b0;
      s_bresp     <= 2'b00;
      s_rresp     <= 2'b00;
      s_rdata     <= '0;
      cpu_wr      <= 1'b0;
      cpu_rd      <= 1'b0;
      cpu_wr_addr <= '0;
      cpu_data_in <= '0;
      cnt         <= 3'd0;
      last_was_wr <= 1'b0;
    end else begin
      s_awready   <= awready_nxt;
      s_wready    <= wready_nxt;
      s_arready   <= arready_nxt;
      s_bvalid    <= bvalid_nxt;
      s_rvalid    <= rvalid_nxt;
      s_bresp     <= bresp_nxt;
      s_rresp     <= RESP_OKAY;
      s_rdata     <= rdata_nxt;
      cpu_wr      <= cpu_wr_nxt;
      cpu_rd      <= cpu_rd_nxt;
      cpu_wr_addr <= addr_nxt;
      cpu_data_in <= data_in_nxt;
      cnt         <= cnt_nxt;
      last_was_wr <= last_was_wr_nxt;
    end
  end

endmodule

// File: tb/tb_axil_mpi_master.sv
// Bench for axil_mpi_master: vector table plus directed arbitration, stall and reset sequences.
module tb_axil_mpi_master;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int AXW = 32;
  localparam int LAT = 1;

  logic           clks = 1'b0;
  logic           reset = 1'b1;
  logic           s_awvalid, s_awready, s_wvalid, s_wready;
  logic [AXW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0]  s_wdata, s_rdata, cpu_data_in, cpu_data_out;
  logic [3:0]     s_wstrb;
  logic           s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]     s_bresp, s_rresp;
  logic           cpu_wr, cpu_rd;
  logic [AW-1:0]  cpu_wr_addr;

  always #5 clks = ~clks;

  axil_mpi_master #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AXW), .RD_LATENCY(LAT)) dut (
    .clks(clks), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_data_out(cpu_data_out)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [11:0] word;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [11:0] word;
    logic [31:0] data;
  } bus_t;

  exp_t        resp_q[$];
  bus_t        wr_q[$];
  logic [11:0] rd_q[$];
  vec_t        vecs[13];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Register-file responder: data registered one cycle after cpu_rd.
  always @(posedge clks) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[1]       <= 32'h11111111;
      mem[4]       <= 32'hCAFE0001;
      mem[32]      <= 32'hA5A5A5A5;
      cpu_data_out <= 32'h0;
    end else begin
      if (cpu_wr) mem[cpu_wr_addr] <= cpu_data_in;
      if (cpu_rd) cpu_data_out <= mem[cpu_wr_addr];
    end
  end

  // Scoreboard: pops bus accesses and responses as the DUT produces them.
  always @(negedge clks) begin
    bus_t        b;
    exp_t        e;
    logic [11:0] w;
    #1;
    if (!reset) begin
      if (cpu_wr) begin
        if (wr_q.size() == 0) begin
          fail_now($sformatf("unexpected_cpu_wr addr=%h data=%h, expected no write", cpu_wr_addr, cpu_data_in));
        end else begin
          b = wr_q.pop_front();
          chk("wr_addr", 32'(cpu_wr_addr), 32'(b.word));
          chk("wr_data", cpu_data_in, b.data);
          chk("wr_excl_rd", 32'(cpu_rd), 32'd0);
        end
      end
      if (cpu_rd) begin
        if (rd_q.size() == 0) begin
          fail_now($sformatf("unexpected_cpu_rd addr=%h, expected no read", cpu_wr_addr));
        end else begin
          w = rd_q.pop_front();
          chk("rd_addr", 32'(cpu_wr_addr), 32'(w));
        end
      end
      if (s_bvalid && s_bready) begin
        if (resp_q.size() == 0) begin
          fail_now($sformatf("unexpected_bresp got %h, expected no response", s_bresp));
        end else begin
          e = resp_q.pop_front();
          chk("b_kind", 32'(e.is_wr), 32'd1);
          chk("bresp", 32'(s_bresp), 32'(e.resp));
        end
      end
      if (s_rvalid && s_rready) begin
        if (resp_q.size() == 0) begin
          fail_now($sformatf("unexpected_rresp rdata=%h, expected no response", s_rdata));
        end else begin
          e = resp_q.pop_front();
          chk("r_kind", 32'(e.is_wr), 32'd0);
          chk("rdata", s_rdata, e.rdata);
          chk("rresp", 32'(s_rresp), 32'd0);
        end
      end
    end
  end

  task automatic idle_inputs();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = 4'h0;
    s_bready = 1'b1; s_rready = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clks);
    reset = 1'b0;
    @(negedge clks);
  endtask

  task automatic wait_grant(output logic aw, output logic ar);
    bit ok = 1'b0;
    aw = 1'b0;
    ar = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clks);
      if (s_awready || s_arready) begin
        ok = 1'b1;
        aw = s_awready & s_wready;
        ar = s_arready;
      end
    end
    if (!ok) fail_now("grant_timeout: no ready within 50 cycles");
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clks);
      if (resp_q.size() == 0) done = 1'b1;
    end
    if (!done) fail_now("response_timeout: scoreboard not drained");
    @(negedge clks);
  endtask

  task automatic issue(input vec_t v);
    logic aw, ar;
    if (v.is_wr) begin
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_awaddr = v.addr; s_wdata = v.data; s_wstrb = v.strb;
    end else begin
      s_arvalid = 1'b1; s_araddr = v.addr;
    end
    wait_grant(aw, ar);
    chk(v.is_wr ? "wr_grant" : "rd_grant", {30'd0, aw, ar}, v.is_wr ? 32'd2 : 32'd1);
    if (v.is_wr) begin
      if (&v.strb) wr_q.push_back('{v.word, v.data});
      resp_q.push_back('{1'b1, v.resp, 32'h0});
    end else begin
      rd_q.push_back(v.word);
      resp_q.push_back('{1'b0, 2'b00, v.rdata});
    end
    @(negedge clks);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    if (v.is_wr) begin
      chk("cpu_wr_at_t1", 32'(cpu_wr), 32'(&v.strb));
      @(negedge clks);
      chk("cpu_wr_one_cycle", 32'(cpu_wr), 32'd0);
      chk("bvalid_at_t2", 32'(s_bvalid), 32'd1);
    end else begin
      chk("cpu_rd_at_t1", 32'(cpu_rd), 32'd1);
      repeat (LAT) @(negedge clks);
      chk("rvalid_early", 32'(s_rvalid), 32'd0);
      @(negedge clks);
      chk("rvalid_at_t2_lat", 32'(s_rvalid), 32'd1);
    end
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic aw, ar;
    bit   seen;
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 12'h002, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 12'h004, 2'b00, 32'hCAFE_0001};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 12'h002, 2'b00, 32'h1234_5678};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 12'h002, 2'b10, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 12'h002, 2'b00, 32'h1234_5678};
    vecs[5]  = '{1'b1, 32'hFFFF_F3FC, 32'h0BAD_F00D, 4'hF, 12'hCFF, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_33FF, 32'h0,         4'h0, 12'hCFF, 2'b00, 32'h0BAD_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 12'h000, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 12'h000, 2'b00, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b1, 32'h0000_3FFC, 32'h0000_0001, 4'hF, 12'hFFF, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 32'hC000_3FFE, 32'h0,         4'h0, 12'hFFF, 2'b00, 32'h0000_0001};
    vecs[11] = '{1'b1, 32'h0000_0004, 32'h0000_0055, 4'h0, 12'h001, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 12'h001, 2'b00, 32'h1111_1111};

    idle_inputs();
    repeat (2) @(negedge clks);
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready", 32'(s_wready), 32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_cpu_wr", 32'(cpu_wr), 32'd0);
    chk("rst_cpu_rd", 32'(cpu_rd), 32'd0);
    chk("rst_addr", 32'(cpu_wr_addr), 32'd0);
    chk("rst_data_in", cpu_data_in, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_bresp", 32'(s_bresp), 32'd0);
    chk("rst_rresp", 32'(s_rresp), 32'd0);
    reset = 1'b0;
    @(negedge clks);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i]);
      if (i == 3) chk("partial_keeps_reg", mem[2], 32'h1234_5678);
    end

    // Simultaneous AW/W/AR after reset: write, then read, then the next write.
    apply_reset();
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = 32'h20; s_wdata = 32'h7777_7777; s_wstrb = 4'hF;
    s_arvalid = 1'b1; s_araddr = 32'h10;
    wait_grant(aw, ar);
    chk("rr1_write_first", {30'd0, aw, ar}, 32'd2);
    wr_q.push_back('{12'h008, 32'h7777_7777});
    resp_q.push_back('{1'b1, 2'b00, 32'h0});
    @(negedge clks);
    s_awaddr = 32'h24; s_wdata = 32'h8888_8888;
    wait_grant(aw, ar);
    chk("rr2_read_next", {30'd0, aw, ar}, 32'd1);
    rd_q.push_back(12'h004);
    resp_q.push_back('{1'b0, 2'b00, 32'hCAFE_0001});
    @(negedge clks);
    s_arvalid = 1'b0;
    wait_grant(aw, ar);
    chk("rr3_write_again", {30'd0, aw, ar}, 32'd2);
    wr_q.push_back('{12'h009, 32'h8888_8888});
    resp_q.push_back('{1'b1, 2'b00, 32'h0});
    @(negedge clks);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    drain();

    // Stalled rready holds the response and blocks new reads.
    s_rready = 1'b0;
    s_arvalid = 1'b1; s_araddr = 32'h80;
    wait_grant(aw, ar);
    chk("stall_grant", {30'd0, aw, ar}, 32'd1);
    rd_q.push_back(12'h020);
    resp_q.push_back('{1'b0, 2'b00, 32'hA5A5_A5A5});
    @(negedge clks);
    s_arvalid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clks);
      if (s_rvalid) seen = 1'b1;
    end
    if (!seen) fail_now("stall_rvalid_timeout");
    s_arvalid = 1'b1; s_araddr = 32'h10;
    for (int n = 0; n < 10; n++) begin
      chk("stall_rvalid", 32'(s_rvalid), 32'd1);
      chk("stall_rdata", s_rdata, 32'hA5A5_A5A5);
      chk("stall_arready", 32'(s_arready), 32'd0);
      @(negedge clks);
    end
    s_rready = 1'b1;
    wait_grant(aw, ar);
    chk("after_stall_grant", {30'd0, aw, ar}, 32'd1);
    rd_q.push_back(12'h004);
    resp_q.push_back('{1'b0, 2'b00, 32'hCAFE_0001});
    @(negedge clks);
    s_arvalid = 1'b0;
    drain();

    // Reset while the read is waiting on data: the response is lost.
    s_arvalid = 1'b1; s_araddr = 32'h80;
    wait_grant(aw, ar);
    chk("midrst_grant", {30'd0, aw, ar}, 32'd1);
    rd_q.push_back(12'h020);
    @(negedge clks);
    s_arvalid = 1'b0;
    @(negedge clks);
    reset = 1'b1;
    @(negedge clks);
    chk("midrst_rvalid", 32'(s_rvalid), 32'd0);
    chk("midrst_rdata", s_rdata, 32'd0);
    chk("midrst_addr", 32'(cpu_wr_addr), 32'd0);
    chk("midrst_cpu_rd", 32'(cpu_rd), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clks);
    chk("midrst_no_rvalid", 32'(s_rvalid), 32'd0);
    chk("midrst_no_pending", 32'(rd_q.size()), 32'd0);
    issue('{1'b0, 32'h0000_0010, 32'h0, 4'h0, 12'h004, 2'b00, 32'hCAFE_0001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_mpi_master.md
# axil_mpi_master

AXI4-Lite slave to MPI register-bus initiator: it turns single-beat AXI4-Lite reads and writes from the shell into `cpu_wr`/`cpu_rd` accesses on the user-logic register bus. It drives the same MPI signals the user-logic register files consume: shared word address, write data, and a registered read-data return. It sits between the shell's BAR/AXI-Lite port and every MPI register bank. At most one transaction is outstanding at a time.

## Interface
Parameters:
- `CPU_ADDR_WIDTH`, 12: MPI word-address width.
- `CPU_DATA_WIDTH`, 32: MPI and AXI data width.
- `AXI_ADDR_WIDTH`, 32: AXI byte-address width. Must be at least CPU_ADDR_WIDTH+2.
- `RD_LATENCY`, 1: cycles after the `cpu_rd` cycle until `cpu_data_out` is valid. Range 1..7.

Ports:
- `clks`  in  1  clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `s_awvalid`/`s_awready`  in/out  1  write-address handshake. `s_awaddr`  in  AXI_ADDR_WIDTH.
- `s_wvalid`/`s_wready`  in/out  1  write-data handshake. `s_wdata`  in  CPU_DATA_WIDTH. `s_wstrb`  in  CPU_DATA_WIDTH/8.
- `s_bvalid`/`s_bready`  out/in  1  write response. `s_bresp`  out  2.
- `s_arvalid`/`s_arready`  in/out  1  read-address handshake. `s_araddr`  in  AXI_ADDR_WIDTH.
- `s_rvalid`/`s_rready`  out/in  1  read response. `s_rdata`  out  CPU_DATA_WIDTH. `s_rresp`  out  2.
- `cpu_wr`  out  1  one-cycle write strobe.
- `cpu_wr_addr`  out  CPU_ADDR_WIDTH  shared word address for reads and writes.
- `cpu_data_in`  out  CPU_DATA_WIDTH  write data.
- `cpu_rd`  out  1  one-cycle read strobe.
- `cpu_data_out`  in  CPU_DATA_WIDTH  registered read data from the responders.

## Operation
- Word address = AXI addr[CPU_ADDR_WIDTH+1:2]. Address bits [1:0] and all bits above CPU_ADDR_WIDTH+1 are ignored.
- FSM states: IDLE, WR, WR_RESP, RD, RD_WAIT, RD_RESP.
- In IDLE, a write is eligible only when `s_awvalid` and `s_wvalid` are both high. A read is eligible when `s_arvalid` is high.
- When only one kind is eligible, grant it. When both are eligible, a round-robin `last_was_wr` flag decides: grant the write if the flag is 0, else the read. The flag is 0 after reset and updates on every grant.
- Write grant: `s_awready` and `s_wready` pulse together for one cycle. Address, data and strb are latched. Next state is WR.
- WR: if `s_wstrb` is all ones, `cpu_wr`=1 for exactly one cycle with address and data driven, and `s_bresp`=OKAY. Otherwise `cpu_wr` stays 0 (partial writes are dropped) and `s_bresp`=SLVERR (2'b10). Next state is WR_RESP.
- WR_RESP: `s_bvalid`=1 until `s_bready`, then return to IDLE.
- Read grant: `s_arready` pulses for one cycle and the address is latched. Next state is RD.
- RD: `cpu_rd`=1 for one cycle with the address driven. Next state is RD_WAIT.
- RD_WAIT: a 3-bit counter counts RD_LATENCY cycles. `cpu_data_out` is captured into `s_rdata` on the final cycle. Next state is RD_RESP.
- RD_RESP: `s_rvalid`=1 with `s_rresp`=OKAY until `s_rready`, then return to IDLE.
- `cpu_wr_addr` holds its last value from the RD cycle through the end of RD_WAIT, and also while idle. It only changes in the cycle a new access is driven.
- `cpu_data_in` changes only in the WR cycle.
- `s_awready`, `s_wready` and `s_arready` are 0 in every state except the IDLE grant cycle.
- No transaction is accepted while a response is pending.
- Reset mid-transaction: all state is cleared immediately. The in-flight access and its response are lost.

Reset values:
- FSM in IDLE.
- All ready, valid, `cpu_wr` and `cpu_rd` = 0.
- `cpu_wr_addr`, `cpu_data_in`, `s_rdata` = 0.
- `s_bresp` and `s_rresp` = 0.

## Timing
- All outputs are registered.
- Write, with the handshake in cycle T: `cpu_wr` high in T+1, `s_bvalid` high from T+2. The earliest next grant is the cycle after the `s_bready` handshake.
- Read, with the handshake in cycle T: `cpu_rd` high in T+1, data sampled at the end of T+1+RD_LATENCY, `s_rvalid` high from T+2+RD_LATENCY.
- A stalled `s_bready` or `s_rready` holds the response and its data stable indefinitely.
- If AW arrives without W (or the reverse), nothing is accepted. The channel waits with its ready low; no single channel is ever accepted alone.

## Test plan
- Write 0x0000_0008 / 0x1234_5678, wstrb=0xF, bready=1 -> `cpu_wr` is one cycle with addr 0x002 and data 0x12345678. Then `s_bvalid` with bresp=0, accepted the cycle after.
- Read araddr 0x10 against a model that registers data 1 cycle after the address (RD_LATENCY=1, register 4 = 0xCAFE0001) -> `cpu_rd` at T+1, `s_rvalid` at T+3, rdata=0xCAFE0001.
- Write with wstrb=0x3 -> no `cpu_wr` pulse, bresp=2'b10, and the model register stays unchanged.
- AW, W and AR all valid in the same cycle, twice in a row after reset -> write granted first, then the read. Exactly one access is on the bus at a time.
- Hold rready=0 for 10 cycles with rdata=0xA5A5A5A5 -> rvalid and rdata stay stable, and a new arvalid is not accepted until the handshake.
- Assert `reset` during RD_WAIT -> outputs return to reset values next edge with no `s_rvalid`. A read issued after reset completes normally.
